// File: rtl/column_scheduler.sv
// Game sequencer for the falling-letter board: shared move-down tick, round-robin
// spawning into free columns, key-to-column routing, scoring and game-over detection.
//
// state  | meaning
// S_IDLE | after reset, waiting for start; keys and bottom hits ignored
// S_PLAY | game running: ticks, spawns, key matches, bottom watch
// S_OVER | a letter hit the bottom; score frozen until the next start
module column_scheduler #(
  parameter int NUM_COLS    = 4,
  parameter int TICK_CYCLES = 50000000,
  parameter int SPAWN_TICKS = 3,
  parameter int SCORE_W     = 8
) (
  input  logic                  clock,
  input  logic                  reset_signal,
  input  logic                  start,
  input  logic                  key_valid,
  input  logic [7:0]            key_code,
  input  logic [NUM_COLS-1:0]   col_active,
  input  logic [NUM_COLS-1:0]   col_bottom,
  input  logic [8*NUM_COLS-1:0] col_letters,
  output logic [NUM_COLS-1:0]   col_spawn,
  output logic [NUM_COLS-1:0]   col_step,
  output logic [NUM_COLS-1:0]   col_clear,
  output logic [SCORE_W-1:0]    score,
  output logic                  game_over,
  output logic                  playing
);

  localparam int PW = $clog2(NUM_COLS);
  localparam int TW = $clog2(TICK_CYCLES);
  localparam int SW = (SPAWN_TICKS > 1) ? $clog2(SPAWN_TICKS) : 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_CYCLES - 1);
  localparam logic [SW-1:0] SPAWN_LAST = SW'(SPAWN_TICKS - 1);
  localparam logic [PW:0]   NC         = (PW+1)'(NUM_COLS);
  localparam logic [PW-1:0] COL_LAST   = PW'(NUM_COLS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  state_t                r_state;
  logic [TW-1:0]         r_tick_cnt;
  logic [SW-1:0]         r_spawn_cnt;
  logic [PW-1:0]         r_rr_ptr;
  logic [SCORE_W-1:0]    r_score;
  logic [NUM_COLS-1:0]   r_col_spawn;
  logic [NUM_COLS-1:0]   r_col_step;
  logic [NUM_COLS-1:0]   r_col_clear;
  logic                  r_game_over;
  logic                  r_playing;

  logic                  w_tick;
  logic                  w_free_found;
  logic [PW-1:0]         w_free_idx;
  logic [PW:0]           w_probe;
  logic [PW-1:0]         w_rr_next;
  logic                  w_hit_any;
  logic [NUM_COLS-1:0]   w_hit_onehot;
  logic                  w_start_game;

  assign w_tick       = (r_tick_cnt == TICK_LAST);
  assign w_start_game = start && (r_state != S_PLAY);

  // First inactive column at or after the round-robin pointer, wrapping.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_probe      = '0;
    for (int k = 0; k < NUM_COLS; k++) begin
      w_probe = {1'b0, r_rr_ptr} + (PW+1)'(k);
      if (w_probe >= NC) w_probe = w_probe - NC;
      if (!w_free_found && !col_active[w_probe[PW-1:0]]) begin
        w_free_found = 1'b1;
        w_free_idx   = w_probe[PW-1:0];
      end
    end
  end

  assign w_rr_next = (w_free_idx == COL_LAST) ? '0 : w_free_idx + 1'b1;

  // Lowest-index active column whose letter equals the typed code.
  always_comb begin
    w_hit_any    = 1'b0;
    w_hit_onehot = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (!w_hit_any && col_active[i] && (col_letters[8*i +: 8] == key_code)) begin
        w_hit_any       = 1'b1;
        w_hit_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_signal) begin
    if (!reset_signal) begin
      r_state     <= S_IDLE;
      r_tick_cnt  <= '0;
      r_spawn_cnt <= '0;
      r_rr_ptr    <= '0;
      r_score     <= '0;
      r_col_spawn <= '0;
      r_col_step  <= '0;
      r_col_clear <= '0;
      r_game_over <= 1'b0;
      r_playing   <= 1'b0;
    end else begin
      r_col_spawn <= '0;
      r_col_step  <= '0;
      r_col_clear <= '0;
      if (w_start_game) begin
        r_state     <= S_PLAY;
        r_col_clear <= '1;
        r_score     <= '0;
        r_tick_cnt  <= '0;
        r_spawn_cnt <= '0;
        r_rr_ptr    <= '0;
        r_game_over <= 1'b0;
        r_playing   <= 1'b1;
      end else begin
        case (r_state)
          S_PLAY: begin
            if (|col_bottom) begin
              // Everything else pending this cycle, including a key hit, is dropped.
              r_state     <= S_OVER;
              r_game_over <= 1'b1;
              r_playing   <= 1'b0;
            end else begin
              r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
              if (w_tick) begin
                r_col_step <= col_active;
                if (r_spawn_cnt < SPAWN_LAST) begin
                  r_spawn_cnt <= r_spawn_cnt + 1'b1;
                end else if (w_free_found) begin
                  r_col_spawn[w_free_idx] <= 1'b1;
                  r_rr_ptr    <= w_rr_next;
                  r_spawn_cnt <= '0;
                end
              end
              if (key_valid && w_hit_any) begin
                r_col_clear <= w_hit_onehot;
                if (r_score != '1) r_score <= r_score + 1'b1;
              end
            end
          end
          S_IDLE, S_OVER: ;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign col_spawn = r_col_spawn;
  assign col_step  = r_col_step;
  assign col_clear = r_col_clear;
  assign score     = r_score;
  assign game_over = r_game_over;
  assign playing   = r_playing;

endmodule

// File: tb/tb_column_scheduler.sv
// Bench for column_scheduler: directed scenarios and random traffic compared every
// cycle against an integer-level model of the game rules.
module tb_column_scheduler;

  localparam int N  = 4;
  localparam int TC = 4;
  localparam int ST = 2;

  logic        clock = 1'b0;
  logic        reset_signal = 1'b0;
  logic        start = 1'b0;
  logic        key_valid = 1'b0;
  logic [7:0]  key_code = 8'h00;
  logic [N-1:0]   col_active = '0;
  logic [N-1:0]   col_bottom = '0;
  logic [8*N-1:0] col_letters = '0;
  logic [N-1:0]   col_spawn, col_step, col_clear;
  logic [7:0]     score;
  logic           game_over, playing;

  int n_checks = 0;
  int n_fail   = 0;

  // model: mode 0 idle, 1 play, 2 over
  int m_mode, m_tick, m_spawn, m_rr, m_score;
  logic [N-1:0] e_spawn, e_step, e_clear;

  column_scheduler #(.NUM_COLS(N), .TICK_CYCLES(TC), .SPAWN_TICKS(ST), .SCORE_W(8)) dut (
    .clock(clock), .reset_signal(reset_signal), .start(start),
    .key_valid(key_valid), .key_code(key_code),
    .col_active(col_active), .col_bottom(col_bottom), .col_letters(col_letters),
    .col_spawn(col_spawn), .col_step(col_step), .col_clear(col_clear),
    .score(score), .game_over(game_over), .playing(playing)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task model_reset();
    m_mode = 0; m_tick = 0; m_spawn = 0; m_rr = 0; m_score = 0;
    e_spawn = '0; e_step = '0; e_clear = '0;
  endtask

  task model_step();
    logic done;
    int   c;
    e_spawn = '0; e_step = '0; e_clear = '0;
    if (m_mode != 1) begin
      if (start) begin
        m_mode = 1; e_clear = '1;
        m_score = 0; m_tick = 0; m_spawn = 0; m_rr = 0;
      end
    end else if (col_bottom != 0) begin
      m_mode = 2;
    end else begin
      if (m_tick == TC - 1) begin
        e_step = col_active;
        if (m_spawn < ST - 1) m_spawn++;
        else begin
          done = 1'b0;
          for (int k = 0; k < N; k++) begin
            c = (m_rr + k) % N;
            if (!done && !col_active[c]) begin
              done = 1'b1; e_spawn[c] = 1'b1; m_rr = (c + 1) % N; m_spawn = 0;
            end
          end
        end
      end
      m_tick = (m_tick + 1) % TC;
      if (key_valid) begin
        done = 1'b0;
        for (int i = 0; i < N; i++) begin
          if (!done && col_active[i] && col_letters[8*i +: 8] == key_code) begin
            done = 1'b1; e_clear[i] = 1'b1;
            if (m_score < 255) m_score++;
          end
        end
      end
    end
  endtask

  task compare_all();
    check("spawn", 32'(col_spawn), 32'(e_spawn));
    check("step",  32'(col_step),  32'(e_step));
    check("clear", 32'(col_clear), 32'(e_clear));
    check("score", 32'(score),     32'(m_score));
    check("game_over", 32'(game_over), 32'(m_mode == 2));
    check("playing",   32'(playing),   32'(m_mode == 1));
  endtask

  task automatic cyc(input logic st, input logic kv, input logic [7:0] kc,
                     input logic [N-1:0] act, input logic [N-1:0] bot);
    @(negedge clock);
    start = st; key_valid = kv; key_code = kc; col_active = act; col_bottom = bot;
    model_step();
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task check_all_zero(input string tag);
    check({tag, "_spawn"}, 32'(col_spawn), 32'h0);
    check({tag, "_step"},  32'(col_step),  32'h0);
    check({tag, "_clear"}, 32'(col_clear), 32'h0);
    check({tag, "_score"}, 32'(score),     32'h0);
    check({tag, "_over"},  32'(game_over), 32'h0);
    check({tag, "_play"},  32'(playing),   32'h0);
  endtask

  function automatic logic [7:0] pick_letter();
    return 8'h41 + 8'($urandom_range(0, 2));
  endfunction

  initial begin
    model_reset();
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clock);
    #2 reset_signal = 1'b1;

    // IDLE: bottom and keys ignored, no ticks
    col_letters = {8'h41, 8'h41, 8'h41, 8'h41};
    repeat (6) cyc(0, 1, 8'h41, 4'b1111, 4'b0010);

    // start, first spawn on the second tick
    cyc(1, 0, 8'h00, '0, '0);
    check("start_clear", 32'(col_clear), 32'hF);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 0, 8'h00, '0, '0);
      if (i == 8) check("first_spawn", 32'(col_spawn), 32'h1);
    end

    // rr_ptr=1 with col 1 busy -> col 2
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 0, 8'h00, 4'b1011, '0);
      if (i == 8) check("rr_spawn", 32'(col_spawn), 32'h4);
    end
    repeat (10) cyc(0, 0, 8'h00, 4'b1111, '0);
    repeat (6)  cyc(0, 0, 8'h00, 4'b1110, '0);

    // key routing
    col_letters = {8'h41, 8'h41, 8'h41, 8'h41};
    cyc(0, 1, 8'h41, 4'b0110, '0);
    check("key_lowest", 32'(col_clear), 32'h2);
    cyc(0, 1, 8'h42, 4'b0110, '0);
    check("key_nomatch", 32'(col_clear), 32'h0);

    // saturation
    repeat (300) cyc(0, 1, 8'h41, 4'b0110, '0);
    check("score_sat", 32'(score), 32'hFF);
    cyc(0, 1, 8'h41, 4'b0110, '0);
    check("sat_clear", 32'(col_clear), 32'h2);

    // bottom with simultaneous hit
    cyc(0, 1, 8'h41, 4'b0110, 4'b0100);
    check("over_flag", 32'(game_over), 32'h1);
    check("over_score", 32'(score), 32'hFF);
    repeat (5) cyc(0, 1, 8'h41, 4'b0110, '0);
    cyc(1, 0, 8'h00, '0, '0);
    check("restart_score", 32'(score), 32'h0);
    check("restart_clear", 32'(col_clear), 32'hF);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [N-1:0] bot;
      for (int i = 0; i < N; i++) col_letters[8*i +: 8] = pick_letter();
      bot = ($urandom_range(0, 59) == 0) ? N'($urandom_range(1, 15)) : '0;
      cyc(($urandom_range(0, 29) == 0), ($urandom_range(0, 2) == 0), pick_letter(),
          N'($urandom), bot);
    end

    // asynchronous reset mid-game
    col_letters = {8'h41, 8'h41, 8'h41, 8'h41};
    cyc(1, 0, 8'h00, '0, '0);
    repeat (5) cyc(0, 1, 8'h41, 4'b0001, '0);
    #1 reset_signal = 1'b0;
    #1 check_all_zero("async_rst");
    model_reset();
    #1 reset_signal = 1'b1;
    repeat (12) cyc(0, 1, 8'h41, 4'b1111, '0);
    cyc(1, 0, 8'h00, 4'b1111, '0);
    repeat (6) cyc(0, 0, 8'h00, 4'b1111, '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/column_scheduler.md
Name: column_scheduler

Overview:
- Top-level game sequencer for the falling-letter board; drives NUM_COLS column state machines.
- Generates the shared move-down tick and schedules new letters into free columns round-robin.
- Routes keyboard codes to the matching column, keeps the score and declares game over.
- Sits between the keyboard decoder, the column instances and the display/score logic.

Parameters:
- NUM_COLS, 4, number of columns scheduled (2..8).
- TICK_CYCLES, 50000000, clock cycles per move-down tick (>=2).
- SPAWN_TICKS, 3, ticks between spawn attempts (>=1).
- SCORE_W, 8, score counter width.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset_signal  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  single-cycle pulse; starts or restarts a game.
- key_valid  in  1  single-cycle strobe; key_code is valid.
- key_code  in  8  letter code typed by the player.
- col_active  in  NUM_COLS  bit i = column i currently holds a falling letter.
- col_bottom  in  NUM_COLS  bit i = column i letter reached the board bottom.
- col_letters  in  8*NUM_COLS  packed letters; column i at [8i+7:8i].
- col_spawn  out  NUM_COLS  one-hot, 1-cycle pulse: load new letter at top.
- col_step  out  NUM_COLS  1-cycle pulse: move letter down one row.
- col_clear  out  NUM_COLS  1-cycle pulse: remove letter (correct hit or restart).
- score  out  SCORE_W  correct hits this game.
- game_over  out  1  high in OVER state.
- playing  out  1  high in PLAY state.

Behaviour:
- Reset (async, reset_signal=0):
  - State IDLE; tick_cnt, spawn_cnt, rr_ptr, score = 0.
  - game_over = 0, playing = 0; col_spawn, col_step, col_clear = 0.
- All outputs registered; every response appears the cycle after the causing input sample.
- States IDLE, PLAY, OVER.
  - IDLE: ignore key_valid and col_bottom. start -> PLAY.
  - PLAY: playing=1. start ignored.
  - OVER: game_over=1, score held, key_valid ignored. start -> PLAY.
- Entering PLAY (from IDLE or OVER):
  - col_clear = all ones for 1 cycle.
  - score, tick_cnt, spawn_cnt, rr_ptr = 0; game_over = 0.
- Tick generation (PLAY only):
  - tick_cnt counts 0..TICK_CYCLES-1 and wraps.
  - tick is asserted when tick_cnt == TICK_CYCLES-1.
  - On tick: col_step = col_active (sampled that cycle).
- Spawn scheduling (PLAY only, evaluated on tick):
  - If spawn_cnt < SPAWN_TICKS-1: spawn_cnt++.
  - Otherwise, search the first column with col_active=0 starting at rr_ptr, wrapping modulo NUM_COLS.
  - Found column c: col_spawn[c]=1, rr_ptr = (c+1) mod NUM_COLS, spawn_cnt = 0.
  - No free column: no spawn; spawn_cnt holds, so the attempt retries next tick.
  - A column spawned on a tick gets no col_step that cycle (it was inactive).
- Key match (PLAY, key_valid=1):
  - match[i] = col_active[i] & (col_letters[i] == key_code).
  - The lowest-index set match bit gets a col_clear pulse; score increments, saturating at all ones.
  - No match: no action, no penalty.
- Game over: any col_bottom bit in PLAY -> OVER next cycle.
  - That cycle, pending spawn/step/clear/score updates are suppressed.
  - A key match in the same cycle is discarded.
- Spawn and key clear in the same cycle are legal and target distinct columns (inactive vs active).

Test Plan:
- Params NUM_COLS=4, TICK_CYCLES=4, SPAWN_TICKS=2. Release reset, pulse start -> col_clear=4'b1111 for 1 cycle, playing=1, score=0; first col_spawn=4'b0001 on the 2nd tick (cycle 8 after start).
- Hold col_active=4'b1011 with rr_ptr=1 at a spawn tick -> col_spawn=4'b0100, rr_ptr=3. With col_active=4'b1111 -> no spawn; spawn occurs on the first tick after any bit drops.
- col_active=4'b0110, letters col1=8'h41, col2=8'h41, key_code=8'h41 strobe -> col_clear=4'b0010, score 0->1. key_code=8'h42 -> no clear, score unchanged.
- Score preloaded to 8'hFF, matching key -> score stays 8'hFF; col_clear still pulses.
- col_bottom=4'b0100 and a matching key_valid in the same cycle -> game_over=1, playing=0, score unchanged, no clear/step/spawn; later start -> score=0, col_clear=4'b1111.
- Assert reset_signal=0 mid-PLAY between clock edges -> all outputs 0 immediately; after release, state IDLE and ticks do not run until start.
